// File: rtl/dphy_pkg.sv
// Shared definitions for the D-PHY LP-TX sequencer: state encoding,
// LP line codes ({Dp,Dn}) and default burst timing constants.
package dphy_pkg;

    typedef enum logic [2:0] {
        ST_STOP  = 3'd0,
        ST_RQST  = 3'd1,
        ST_PRPR  = 3'd2,
        ST_ZERO  = 3'd3,
        ST_DATA  = 3'd4,
        ST_TRAIL = 3'd5,
        ST_EXIT  = 3'd6
    } state_t;

    // Line codes are {Dp, Dn}
    typedef enum logic [1:0] {
        LP00 = 2'b00,
        LP01 = 2'b01,
        LP11 = 2'b11
    } lp_code_t;

    localparam int unsigned DEF_T_LPX        = 8;
    localparam int unsigned DEF_T_HS_PREPARE = 16;
    localparam int unsigned DEF_T_HS_ZERO    = 24;
    localparam int unsigned DEF_T_HS_TRAIL   = 12;
    localparam int unsigned DEF_T_HS_EXIT    = 24;

    // Counter preload for a state lasting max(t,1) cycles
    function automatic int unsigned load_of(input int unsigned t);
        return (t == 0) ? 0 : t - 1;
    endfunction

endpackage

// File: rtl/dphy_tcnt.sv
// Load-and-decrement timing counter; o_zero flags that the current timed
// state has reached its last cycle.
module dphy_tcnt #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dphy_lptx_ml.sv
// Multi-lane D-PHY LP-TX burst sequencer (STOP/RQST/PRPR/ZERO/DATA/TRAIL/EXIT).
// All outputs are registered decodes of the next state.
// Optional macro DPHY_LPTX_TIMING_REG_EN adds Cfg* timing ports, shadowed in STOP.
// During HS phases masked lanes hold LP-00 on the (disabled) LP drivers.
module dphy_lptx_ml
    import dphy_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int CNT_W        = 8,
    parameter int T_LPX        = 8,
    parameter int T_HS_PREPARE = 16,
    parameter int T_HS_ZERO    = 24,
    parameter int T_HS_TRAIL   = 12,
    parameter int T_HS_EXIT    = 24
) (
    input  logic                 LPTX_CLK,
    input  logic                 TxRst_n,
    input  logic                 LPTX_EN,
    input  logic                 TxRequestHS,
    input  logic [NUM_LANES-1:0] LaneMask,
    output logic [NUM_LANES-1:0] LP_Dp,
    output logic [NUM_LANES-1:0] LP_Dn,
    output logic [NUM_LANES-1:0] LP_OE,
    output logic [NUM_LANES-1:0] HSTX_EN,
    output logic                 HSCLK_EN,
    output logic                 TxReadyHS,
    output logic                 TxStopState
`ifdef DPHY_LPTX_TIMING_REG_EN
    ,
    input  logic [CNT_W-1:0]     CfgTLpx,
    input  logic [CNT_W-1:0]     CfgTHsPrepare,
    input  logic [CNT_W-1:0]     CfgTHsZero,
    input  logic [CNT_W-1:0]     CfgTHsTrail,
    input  logic [CNT_W-1:0]     CfgTHsExit
`endif
);

    state_t                 r_state;
    state_t                 w_next;
    logic [NUM_LANES-1:0]   r_mask;
    logic [NUM_LANES-1:0]   w_mask;
    logic [CNT_W-1:0]       w_load_val;
    logic                   w_load;
    logic                   w_zero;
    logic [CNT_W-1:0]       w_t_lpx;
    logic [CNT_W-1:0]       w_t_prep;
    logic [CNT_W-1:0]       w_t_zero;
    logic [CNT_W-1:0]       w_t_trail;
    logic [CNT_W-1:0]       w_t_exit;

    logic [NUM_LANES-1:0]   r_dp, r_dn, r_oe, r_hs;
    logic                   r_hsclk, r_rdy, r_stop;
    logic [NUM_LANES-1:0]   w_dp, w_dn, w_oe, w_hs;
    logic                   w_hsclk, w_rdy, w_stop;
    lp_code_t               w_code;

`ifdef DPHY_LPTX_TIMING_REG_EN
    logic [CNT_W-1:0] r_t_lpx, r_t_prep, r_t_zero, r_t_trail, r_t_exit;

    // Shadow the timing configuration while idle so a burst sees stable values
    always_ff @(posedge LPTX_CLK or negedge TxRst_n) begin
        if (!TxRst_n) begin
            r_t_lpx   <= CNT_W'(T_LPX);
            r_t_prep  <= CNT_W'(T_HS_PREPARE);
            r_t_zero  <= CNT_W'(T_HS_ZERO);
            r_t_trail <= CNT_W'(T_HS_TRAIL);
            r_t_exit  <= CNT_W'(T_HS_EXIT);
        end else if (r_state == ST_STOP) begin
            r_t_lpx   <= CfgTLpx;
            r_t_prep  <= CfgTHsPrepare;
            r_t_zero  <= CfgTHsZero;
            r_t_trail <= CfgTHsTrail;
            r_t_exit  <= CfgTHsExit;
        end
    end

    // RQST is loaded on the STOP exit edge, so it takes the live value being shadowed
    assign w_t_lpx   = (r_state == ST_STOP) ? CfgTLpx : r_t_lpx;
    assign w_t_prep  = r_t_prep;
    assign w_t_zero  = r_t_zero;
    assign w_t_trail = r_t_trail;
    assign w_t_exit  = r_t_exit;
`else
    assign w_t_lpx   = CNT_W'(T_LPX);
    assign w_t_prep  = CNT_W'(T_HS_PREPARE);
    assign w_t_zero  = CNT_W'(T_HS_ZERO);
    assign w_t_trail = CNT_W'(T_HS_TRAIL);
    assign w_t_exit  = CNT_W'(T_HS_EXIT);
`endif

    // The mask is latched on the STOP->RQST edge; decode must see it the same cycle
    assign w_mask = (r_state == ST_STOP) ? LaneMask : r_mask;

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_STOP:  if (TxRequestHS && LPTX_EN && (|LaneMask)) w_next = ST_RQST;
            ST_RQST:  if (w_zero) w_next = ST_PRPR;
            ST_PRPR:  if (w_zero) w_next = ST_ZERO;
            ST_ZERO:  if (w_zero) w_next = TxRequestHS ? ST_DATA : ST_TRAIL;
            ST_DATA:  if (!TxRequestHS) w_next = ST_TRAIL;
            ST_TRAIL: if (w_zero) w_next = ST_EXIT;
            ST_EXIT:  if (w_zero) w_next = ST_STOP;
            default:  w_next = ST_STOP;
        endcase
    end

    // Counter preload for the state being entered
    always_comb begin
        w_load     = (w_next != r_state);
        w_load_val = '0;
        case (w_next)
            ST_RQST:  w_load_val = CNT_W'(load_of(32'(w_t_lpx)));
            ST_PRPR:  w_load_val = CNT_W'(load_of(32'(w_t_prep)));
            ST_ZERO:  w_load_val = CNT_W'(load_of(32'(w_t_zero)));
            ST_TRAIL: w_load_val = CNT_W'(load_of(32'(w_t_trail)));
            ST_EXIT:  w_load_val = CNT_W'(load_of(32'(w_t_exit)));
            default:  w_load_val = '0;
        endcase
    end

    dphy_tcnt #(
        .CNT_W (CNT_W)
    ) u_tcnt (
        .i_clk      (LPTX_CLK),
        .i_rst_n    (TxRst_n),
        .i_load     (w_load),
        .i_en       (1'b1),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // Output decode of the next state; unmasked lanes stay LP-11 with LP_OE=1
    always_comb begin
        w_code  = LP11;
        w_oe    = '1;
        w_hs    = '0;
        w_hsclk = 1'b0;
        w_rdy   = 1'b0;
        w_stop  = 1'b0;
        case (w_next)
            ST_STOP: begin
                w_oe   = {NUM_LANES{LPTX_EN}};
                w_stop = LPTX_EN;
            end
            ST_RQST: w_code = LP01;
            ST_PRPR: begin
                w_code  = LP00;
                w_hsclk = 1'b1;
            end
            ST_ZERO, ST_DATA, ST_TRAIL: begin
                w_code  = LP00;
                w_oe    = ~w_mask;
                w_hs    = w_mask;
                w_hsclk = 1'b1;
                w_rdy   = (w_next == ST_DATA);
            end
            default: w_code = LP11;
        endcase
        w_dp = ~w_mask | {NUM_LANES{w_code[1]}};
        w_dn = ~w_mask | {NUM_LANES{w_code[0]}};
    end

    // State, latched mask and registered outputs
    always_ff @(posedge LPTX_CLK or negedge TxRst_n) begin
        if (!TxRst_n) begin
            r_state <= ST_STOP;
            r_mask  <= '0;
            r_dp    <= '1;
            r_dn    <= '1;
            r_oe    <= '0;
            r_hs    <= '0;
            r_hsclk <= 1'b0;
            r_rdy   <= 1'b0;
            r_stop  <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_STOP) && (w_next == ST_RQST)) begin
                r_mask <= LaneMask;
            end
            r_dp    <= w_dp;
            r_dn    <= w_dn;
            r_oe    <= w_oe;
            r_hs    <= w_hs;
            r_hsclk <= w_hsclk;
            r_rdy   <= w_rdy;
            r_stop  <= w_stop;
        end
    end

    assign LP_Dp       = r_dp;
    assign LP_Dn       = r_dn;
    assign LP_OE       = r_oe;
    assign HSTX_EN     = r_hs;
    assign HSCLK_EN    = r_hsclk;
    assign TxReadyHS   = r_rdy;
    assign TxStopState = r_stop;

endmodule

// File: tb/tb_dphy_lptx_ml.sv
// Scoreboard bench for dphy_lptx_ml: expected output snapshots are queued
// per clock edge (or per reset assertion) and a monitor compares them.
module tb_dphy_lptx_ml;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       req   = 1'b0;
    logic [3:0] mask  = 4'b0000;

    logic [3:0] LP_Dp, LP_Dn, LP_OE, HSTX_EN;
    logic       HSCLK_EN, TxReadyHS, TxStopState;

    dphy_lptx_ml #(
        .NUM_LANES    (4),
        .CNT_W        (8),
        .T_LPX        (8),
        .T_HS_PREPARE (16),
        .T_HS_ZERO    (24),
        .T_HS_TRAIL   (12),
        .T_HS_EXIT    (24)
    ) dut (
        .LPTX_CLK    (clk),
        .TxRst_n     (rst_n),
        .LPTX_EN     (en),
        .TxRequestHS (req),
        .LaneMask    (mask),
        .LP_Dp       (LP_Dp),
        .LP_Dn       (LP_Dn),
        .LP_OE       (LP_OE),
        .HSTX_EN     (HSTX_EN),
        .HSCLK_EN    (HSCLK_EN),
        .TxReadyHS   (TxReadyHS),
        .TxStopState (TxStopState)
`ifdef DPHY_LPTX_TIMING_REG_EN
        ,
        .CfgTLpx       (8'd8),
        .CfgTHsPrepare (8'd16),
        .CfgTHsZero    (8'd24),
        .CfgTHsTrail   (8'd12),
        .CfgTHsExit    (8'd24)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        string       nm;
        logic [18:0] v;
    } exp_t;

    exp_t q[$];
    exp_t rq[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [18:0] act;
    assign act = {LP_Dp, LP_Dn, LP_OE, HSTX_EN, HSCLK_EN, TxReadyHS, TxStopState};

    function automatic logic [18:0] mk(input logic [3:0] dp, input logic [3:0] dn,
                                       input logic [3:0] oe, input logic [3:0] hs,
                                       input logic hc, input logic rdy, input logic stp);
        return {dp, dn, oe, hs, hc, rdy, stp};
    endfunction

    task automatic check(input exp_t e);
        n_cmp++;
        if (act !== e.v) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got dp/dn/oe/hs/clk/rdy/stop=%b want %b",
                     e.nm, e.cyc, act, e.v);
        end
    endtask

    task automatic push_rng(input string nm, input int unsigned a, input int unsigned b,
                            input logic [18:0] v);
        for (int unsigned k = a; k <= b; k++) begin
            exp_t e;
            e.cyc = k;
            e.nm  = nm;
            e.v   = v;
            q.push_back(e);
        end
    endtask

    task automatic push_rst(input string nm, input logic [18:0] v);
        exp_t e;
        e.cyc = cyc;
        e.nm  = nm;
        e.v   = v;
        rq.push_back(e);
    endtask

    // Wait for the falling edge just before rising edge number c
    task automatic at_edge(input int unsigned c);
        while (cyc < c - 1) @(negedge clk);
    endtask

    // Cycle monitor: compare every expectation due at this edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0 && q[0].cyc <= cyc) check(q.pop_front());
        end
    end

    // Reset monitor: outputs must fall to reset values without a clock edge
    always @(negedge rst_n) begin
        #1;
        if (rq.size() > 0) check(rq.pop_front());
    end

    initial begin
        logic [18:0] v_rst, v_stop, v_stop_dis;
        logic [18:0] a_rqst, a_prpr, a_zero, a_data, v_exit;
        logic [18:0] b_rqst, b_prpr, b_zero;
        int unsigned b, e0, f, g, r;

        v_rst      = mk(4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
        v_stop     = mk(4'b1111, 4'b1111, 4'b1111, 4'b0000, 0, 0, 1);
        v_stop_dis = mk(4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
        v_exit     = mk(4'b1111, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0);
        // mask 0011: lanes 0,1 active
        a_rqst = mk(4'b1100, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0);
        a_prpr = mk(4'b1100, 4'b1100, 4'b1111, 4'b0000, 1, 0, 0);
        a_zero = mk(4'b1100, 4'b1100, 4'b1100, 4'b0011, 1, 0, 0);
        a_data = mk(4'b1100, 4'b1100, 4'b1100, 4'b0011, 1, 1, 0);
        // mask 1111: all lanes active
        b_rqst = mk(4'b0000, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0);
        b_prpr = mk(4'b0000, 4'b0000, 4'b1111, 4'b0000, 1, 0, 0);
        b_zero = mk(4'b0000, 4'b0000, 4'b0000, 4'b1111, 1, 0, 0);

        push_rst("reset_state", v_rst);
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        en    = 1'b1;
        mask  = 4'b0011;
        rst_n = 1'b1;
        b = cyc;
        push_rng("idle_stop", b + 1, b + 3, v_stop);

        // Burst 1: request sampled at edge e0, 10 DATA cycles
        e0 = b + 4;
        f  = e0 + 95;
        at_edge(e0);
        req = 1'b1;
        push_rng("b1_rqst_lp01", e0,      e0 + 7,  a_rqst);
        push_rng("b1_prpr_lp00", e0 + 8,  e0 + 23, a_prpr);
        push_rng("b1_hs_zero",   e0 + 24, e0 + 47, a_zero);
        push_rng("b1_data_rdy",  e0 + 48, e0 + 57, a_data);
        push_rng("b1_trail",     e0 + 58, e0 + 69, a_zero);
        push_rng("b1_exit",      e0 + 70, e0 + 93, v_exit);
        push_rng("b1_stop",      e0 + 94, e0 + 94, v_stop);
        // Burst 2: request seen in EXIT only honoured at f, dropped in RQST
        push_rng("b2_rqst_lp01", f,      f + 7,  b_rqst);
        push_rng("b2_prpr_lp00", f + 8,  f + 23, b_prpr);
        push_rng("b2_hs_zero",   f + 24, f + 47, b_zero);
        push_rng("b2_trail",     f + 48, f + 59, b_zero);
        push_rng("b2_exit",      f + 60, f + 83, v_exit);
        push_rng("b2_stop",      f + 84, f + 86, v_stop);

        at_edge(e0 + 30);
        mask = 4'b1111;            // ignored: already latched
        at_edge(e0 + 58);
        req = 1'b0;
        at_edge(e0 + 80);
        req = 1'b1;                // during EXIT
        at_edge(f + 1);
        req = 1'b0;                // early drop

        // Gating: zero mask, then LPTX_EN low
        at_edge(f + 87);
        mask = 4'b0000;
        req  = 1'b1;
        push_rng("gate_mask0", f + 87, f + 91, v_stop);
        at_edge(f + 92);
        mask = 4'b0011;
        en   = 1'b0;
        push_rng("gate_lptx_dis", f + 92, f + 96, v_stop_dis);

        // Burst 3: reset asserted while in HS-zero
        g = f + 97;
        at_edge(g);
        en = 1'b1;
        push_rng("b3_rqst_lp01", g,      g + 7,  a_rqst);
        push_rng("b3_prpr_lp00", g + 8,  g + 23, a_prpr);
        push_rng("b3_hs_zero",   g + 24, g + 30, a_zero);
        at_edge(g + 31);
        req = 1'b0;
        push_rst("reset_mid_burst", v_rst);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        push_rng("post_reset_stop", r + 1, r + 3, v_stop);
        at_edge(r + 5);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s @cyc %0d: expectation never compared", e.nm, e.cyc);
        end
        while (rq.size() > 0) begin
            exp_t e;
            e = rq.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: reset expectation never compared", e.nm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
